// File: rtl/vga_hvsync_generator.sv
// VGA raster timing generator: free-running pixel/line counters, registered
// active-low syncs and a combinational visible-area flag.
module vga_hvsync_generator #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_BOTTOM  = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_TOP     = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] hpos,
    output logic [9:0] vpos
);

    localparam logic [9:0] HDisplay   = 10'(H_DISPLAY);
    localparam logic [9:0] HSyncStart = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HSyncEnd   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] HMax       = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] VDisplay   = 10'(V_DISPLAY);
    localparam logic [9:0] VSyncStart = 10'(V_DISPLAY + V_BOTTOM);
    localparam logic [9:0] VSyncEnd   = 10'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);
    localparam logic [9:0] VMax       = 10'(V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1);

    logic [9:0] hpos_q, hpos_d;
    logic [9:0] vpos_q, vpos_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;

    always_comb begin
        hpos_d = hpos_q + 10'd1;
        vpos_d = vpos_q;
        if (hpos_q == HMax) begin
            hpos_d = 10'd0;
            vpos_d = (vpos_q == VMax) ? 10'd0 : vpos_q + 10'd1;
        end
    end

    // Syncs decode the current position, so they trail it by one clock.
    always_comb begin
        hsync_d = !((hpos_q >= HSyncStart) && (hpos_q <= HSyncEnd));
        vsync_d = !((vpos_q >= VSyncStart) && (vpos_q <= VSyncEnd));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hpos_q  <= 10'd0;
            vpos_q  <= 10'd0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            hpos_q  <= hpos_d;
            vpos_q  <= vpos_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign hpos       = hpos_q;
    assign vpos       = vpos_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign display_on = (hpos_q < HDisplay) && (vpos_q < VDisplay);

endmodule

// File: tb/tb_vga_hvsync_generator.sv
// Bench: full-size instance for line-level vectors, shrunken instance for
// frame-level and randomized-reset checks against an arithmetic raster model.
module tb_vga_hvsync_generator;

    // Shrunken raster so whole frames fit in a short run.
    localparam int unsigned HD_S = 64, HF_S = 4, HS_S = 8, HB_S = 4;
    localparam int unsigned VD_S = 48, VB_S = 2, VS_S = 2, VT_S = 3;
    localparam int unsigned HT_S    = HD_S + HF_S + HS_S + HB_S;
    localparam int unsigned VTOT_S  = VD_S + VB_S + VS_S + VT_S;
    localparam int unsigned FRAME_S = HT_S * VTOT_S;
    localparam int unsigned HSS_S   = HD_S + HF_S;
    localparam int unsigned HSE_S   = HSS_S + HS_S - 1;
    localparam int unsigned VSS_S   = VD_S + VB_S;
    localparam int unsigned VSE_S   = VSS_S + VS_S - 1;

    logic       clk = 1'b0;
    logic       rst_b = 1'b1, rst_s = 1'b1;
    logic       hsync_b, vsync_b, de_b, hsync_s, vsync_s, de_s;
    logic [9:0] hpos_b, vpos_b, hpos_s, vpos_s;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    vga_hvsync_generator u_big (
        .clk        (clk),
        .reset      (rst_b),
        .hsync      (hsync_b),
        .vsync      (vsync_b),
        .display_on (de_b),
        .hpos       (hpos_b),
        .vpos       (vpos_b)
    );

    vga_hvsync_generator #(
        .H_DISPLAY (HD_S), .H_FRONT (HF_S), .H_SYNC (HS_S), .H_BACK (HB_S),
        .V_DISPLAY (VD_S), .V_BOTTOM (VB_S), .V_SYNC (VS_S), .V_TOP (VT_S)
    ) u_small (
        .clk        (clk),
        .reset      (rst_s),
        .hsync      (hsync_s),
        .vsync      (vsync_s),
        .display_on (de_s),
        .hpos       (hpos_s),
        .vpos       (vpos_s)
    );

    typedef struct {
        int unsigned steps;
        logic        rst;
        logic [9:0]  h;
        logic [9:0]  v;
        logic        hs;
        logic        vs;
        logic        de;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [22:0] act, input logic [22:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got h=%0d v=%0d hs=%b vs=%b de=%b, expected h=%0d v=%0d hs=%b vs=%b de=%b",
                     name, act[22:13], act[12:3], act[2], act[1], act[0],
                     exp[22:13], exp[12:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic check_int(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Raster state n clocks after the last reset edge, derived from timing rules.
    function automatic logic [22:0] ref_s(input int unsigned n);
        int unsigned p, h, v, q;
        logic hs, vs, de;
        p  = n % FRAME_S;
        h  = p % HT_S;
        v  = p / HT_S;
        de = (h < HD_S) && (v < VD_S);
        hs = 1'b1;
        vs = 1'b1;
        if (n != 0) begin
            q  = (n - 1) % FRAME_S;
            hs = !(((q % HT_S) >= HSS_S) && ((q % HT_S) <= HSE_S));
            vs = !(((q / HT_S) >= VSS_S) && ((q / HT_S) <= VSE_S));
        end
        return {10'(h), 10'(v), hs, vs, de};
    endfunction

    function automatic logic [22:0] pack_b();
        return {hpos_b, vpos_b, hsync_b, vsync_b, de_b};
    endfunction

    function automatic logic [22:0] pack_s();
        return {hpos_s, vpos_s, hsync_s, vsync_s, de_s};
    endfunction

    initial begin
        vec_t        tbl[10];
        int unsigned n, cnt_lo, first_lo, rise_at, vs_lo, hs_lo, de_hi, zeros;
        logic        prev;

        tbl[0] = '{3,   1'b1, 10'd0,   10'd0, 1'b1, 1'b1, 1'b1};
        tbl[1] = '{1,   1'b0, 10'd1,   10'd0, 1'b1, 1'b1, 1'b1};
        tbl[2] = '{638, 1'b0, 10'd639, 10'd0, 1'b1, 1'b1, 1'b1};
        tbl[3] = '{1,   1'b0, 10'd640, 10'd0, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{16,  1'b0, 10'd656, 10'd0, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{1,   1'b0, 10'd657, 10'd0, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{95,  1'b0, 10'd752, 10'd0, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{1,   1'b0, 10'd753, 10'd0, 1'b1, 1'b1, 1'b0};
        tbl[8] = '{46,  1'b0, 10'd799, 10'd0, 1'b1, 1'b1, 1'b0};
        tbl[9] = '{1,   1'b0, 10'd0,   10'd1, 1'b1, 1'b1, 1'b1};

        // Full-size instance: start from an arbitrary position, then the table.
        step();
        rst_b = 1'b0;
        repeat ($urandom_range(1, 700)) step();
        for (int i = 0; i < 10; i++) begin
            rst_b = tbl[i].rst;
            repeat (tbl[i].steps) step();
            check($sformatf("vec%0d", i), pack_b(),
                  {tbl[i].h, tbl[i].v, tbl[i].hs, tbl[i].vs, tbl[i].de});
        end

        // Hsync window over one whole line.
        cnt_lo = 0; first_lo = 9999; rise_at = 9999; prev = hsync_b;
        repeat (800) begin
            step();
            if (!hsync_b) cnt_lo++;
            if (!hsync_b && prev) first_lo = hpos_b;
            if (hsync_b && !prev) rise_at = hpos_b;
            prev = hsync_b;
        end
        check_int("hsync_low_clocks", cnt_lo, 96);
        check_int("hsync_first_low_hpos", first_lo, 657);
        check_int("hsync_rise_hpos", rise_at, 753);
        check_int("line_period_vpos", vpos_b, 2);

        // Shrunken instance: one full frame from reset.
        rst_s = 1'b1;
        step();
        check("small_reset", pack_s(), ref_s(0));
        rst_s = 1'b0;
        vs_lo = 0; hs_lo = 0; de_hi = 0;
        for (int i = 1; i <= FRAME_S; i++) begin
            step();
            if (!vsync_s) vs_lo++;
            if (!hsync_s) hs_lo++;
            if (de_s) de_hi++;
            if (i == FRAME_S - 1) check("frame_last_pixel", pack_s(), ref_s(i));
        end
        check("frame_wrap", pack_s(), ref_s(0) & 23'h7ffff8 | {20'd0, hsync_s, vsync_s, de_s});
        check_int("frame_wrap_hpos", hpos_s, 0);
        check_int("frame_wrap_vpos", vpos_s, 0);
        check_int("vsync_low_clocks", vs_lo, VS_S * HT_S);
        check_int("hsync_low_per_frame", hs_lo, HS_S * VTOT_S);
        check_int("display_on_clocks", de_hi, HD_S * VD_S);

        // Mid-frame reset, then a complete frame with no early wrap.
        repeat (30 * HT_S + 40) step();
        check("pre_midreset_pos", pack_s(), ref_s(30 * HT_S + 40));
        rst_s = 1'b1;
        step();
        check("midreset", pack_s(), ref_s(0));
        rst_s = 1'b0;
        zeros = 0;
        for (int i = 1; i < FRAME_S; i++) begin
            step();
            if (hpos_s == 10'd0 && vpos_s == 10'd0) zeros++;
        end
        check_int("early_origin_after_midreset", zeros, 0);
        step();
        check("frame_after_midreset", pack_s(), ref_s(FRAME_S));

        // Randomized reset pulses, every clock compared against the model.
        n = 0;
        rst_s = 1'b1;
        step();
        rst_s = 1'b0;
        for (int i = 0; i < 12000; i++) begin
            rst_s = ($urandom_range(0, 2999) == 0) || (rst_s && ($urandom_range(0, 1) == 1));
            step();
            n = rst_s ? 0 : n + 1;
            check("random_cycle", pack_s(), ref_s(n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
